exec_unit: RTL and testbench

- Combined execute/memory stage for the 8-bit pipelined MIPS-style processor.
- Contains three independent sub-functions sharing one clock and reset:
  - 8-bit ALU with carry and zero flags.
  - 8-bit barrel shifter/rotator with carry and zero flags.
  - 256x8 data memory.
- ALU and shifter are purely combinational. The memory has a synchronous write and a combinational read, so a load's data is available in the same cycle for register write-back.

---
 rtl/exec_unit.sv | 99 +++++++++
 tb/tb_exec_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Execute/memory stage of the 8-bit MIPS-style pipeline: combinational ALU,
// combinational barrel shifter, and a 256x8 data memory with async-clear.
module exec_unit #(
  parameter int MEM_DEPTH = 256,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic              alu_cin,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_co,
  output logic              alu_z,
  input  logic [DATA_W-1:0] shift_data,
  input  logic [2:0]        bitcount,
  input  logic              dir,
  input  logic              sh_robar,
  output logic [DATA_W-1:0] shift_out,
  output logic              shift_c,
  output logic              shift_z,
  input  logic              mem_write,
  input  logic [7:0]        mem_addr,
  input  logic [DATA_W-1:0] mem_write_data,
  output logic [DATA_W-1:0] mem_out_data
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR   = 3'b011,
    OP_XOR = 3'b100, OP_PASB = 3'b101, OP_PASA = 3'b110, OP_NOTA = 3'b111
  } alu_op_e;

  // ---------------- ALU ----------------
  logic [DATA_W:0] alu_wide;

  always_comb begin
    alu_wide = '0;
    unique case (alu_op_e'(alu_op))
      // Bit DATA_W of the 9-bit result is the carry for ADD and the borrow for SUB.
      OP_ADD:  alu_wide = {1'b0, alu_a} + {1'b0, alu_b} + {{DATA_W{1'b0}}, alu_cin};
      OP_SUB:  alu_wide = {1'b0, alu_a} - {1'b0, alu_b} - {{DATA_W{1'b0}}, alu_cin};
      OP_AND:  alu_wide = {1'b0, alu_a & alu_b};
      OP_OR:   alu_wide = {1'b0, alu_a | alu_b};
      OP_XOR:  alu_wide = {1'b0, alu_a ^ alu_b};
      OP_PASB: alu_wide = {1'b0, alu_b};
      OP_PASA: alu_wide = {1'b0, alu_a};
      OP_NOTA: alu_wide = {1'b0, ~alu_a};
      default: alu_wide = '0;
    endcase
  end

  assign alu_out = alu_wide[DATA_W-1:0];
  assign alu_co  = alu_wide[DATA_W];
  assign alu_z   = (alu_out == '0);

  // ---------------- Barrel shifter ----------------
  logic [DATA_W:0]   shl_wide, shr_wide;
  logic [DATA_W-1:0] rotl, rotr;
  logic [2:0]        neg_n;

  // The extra bit catches the last bit shifted out, which is the carry.
  assign shl_wide = {1'b0, shift_data} << bitcount;
  assign shr_wide = {shift_data, 1'b0} >> bitcount;
  // 3-bit negate gives 8-n for n>0 and 0 for n=0, so n=0 rotates to data.
  assign neg_n    = 3'd0 - bitcount;
  assign rotl     = (shift_data << bitcount) | (shift_data >> neg_n);
  assign rotr     = (shift_data >> bitcount) | (shift_data << neg_n);

  always_comb begin
    shift_out = shift_data;
    shift_c   = 1'b0;
    unique case ({sh_robar, dir})
      2'b10: begin shift_out = shl_wide[DATA_W-1:0]; shift_c = shl_wide[DATA_W]; end
      2'b11: begin shift_out = shr_wide[DATA_W:1];   shift_c = shr_wide[0];      end
      2'b00: begin shift_out = rotl;                 shift_c = rotl[0];          end
      2'b01: begin shift_out = rotr;                 shift_c = rotr[DATA_W-1];   end
      default: ;
    endcase
    if (bitcount == 3'd0) shift_c = 1'b0;
  end

  assign shift_z = (shift_out == '0);

  // ---------------- Data memory ----------------
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // An X on mem_write takes the else path of the if, so it never writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_write_data;
    end
  end

  assign mem_out_data = mem[mem_addr];

endmodule

// File: tb/tb_exec_unit.sv
// Directed self-checking bench for exec_unit: ALU, shifter and data memory.
module tb_exec_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic       alu_cin;
  logic [7:0] alu_out;
  logic       alu_co, alu_z;
  logic [7:0] shift_data;
  logic [2:0] bitcount;
  logic       dir, sh_robar;
  logic [7:0] shift_out;
  logic       shift_c, shift_z;
  logic       mem_write;
  logic [7:0] mem_addr, mem_write_data, mem_out_data;

  int n_tests = 0;
  int n_fail  = 0;

  exec_unit dut (
    .clk(clk), .reset(reset),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_co(alu_co), .alu_z(alu_z),
    .shift_data(shift_data), .bitcount(bitcount), .dir(dir), .sh_robar(sh_robar),
    .shift_out(shift_out), .shift_c(shift_c), .shift_z(shift_z),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_out_data(mem_out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic alu_vec(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input logic [7:0] e_out,
                         input logic e_co, input logic e_z);
    alu_op = op; alu_a = a; alu_b = b; alu_cin = cin;
    #1;
    chk({tag, ".out"}, {1'b0, alu_out}, {1'b0, e_out});
    chk({tag, ".co"},  {8'b0, alu_co},  {8'b0, e_co});
    chk({tag, ".z"},   {8'b0, alu_z},   {8'b0, e_z});
  endtask

  task automatic sh_vec(input string tag, input logic [7:0] d, input logic [2:0] n,
                        input logic dr, input logic logical, input logic [7:0] e_out,
                        input logic e_c, input logic e_z);
    shift_data = d; bitcount = n; dir = dr; sh_robar = logical;
    #1;
    chk({tag, ".out"}, {1'b0, shift_out}, {1'b0, e_out});
    chk({tag, ".c"},   {8'b0, shift_c},   {8'b0, e_c});
    chk({tag, ".z"},   {8'b0, shift_z},   {8'b0, e_z});
  endtask

  // Inputs change #1 after a rising edge, so they are stable at the next one.
  task automatic mem_wr(input logic [7:0] a, input logic [7:0] d);
    mem_addr = a; mem_write_data = d; mem_write = 1'b1;
    @(posedge clk); #1;
    mem_write = 1'b0;
  endtask

  task automatic mem_rd(input string tag, input logic [7:0] a, input logic [7:0] e);
    mem_addr = a;
    #1;
    chk(tag, {1'b0, mem_out_data}, {1'b0, e});
  endtask

  initial begin
    reset = 1'b1; mem_write = 1'b0; mem_addr = 8'h00; mem_write_data = 8'h00;
    alu_op = 3'b000; alu_a = 8'h00; alu_b = 8'h00; alu_cin = 1'b0;
    shift_data = 8'h00; bitcount = 3'd0; dir = 1'b0; sh_robar = 1'b0;

    // ALU
    alu_vec("add_carry", 3'b000, 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 1'b0);
    alu_vec("add_zero",  3'b000, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    alu_vec("sub_borrow",3'b001, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0);
    alu_vec("sub_eq",    3'b001, 8'h07, 8'h07, 1'b0, 8'h00, 1'b0, 1'b1);
    alu_vec("sub_cin",   3'b001, 8'h07, 8'h06, 1'b1, 8'h00, 1'b0, 1'b1);
    alu_vec("sub_cin_b", 3'b001, 8'h07, 8'h07, 1'b1, 8'hFF, 1'b1, 1'b0);
    alu_vec("and",       3'b010, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0);
    alu_vec("or",        3'b011, 8'hF0, 8'h0C, 1'b1, 8'hFC, 1'b0, 1'b0);
    alu_vec("xor",       3'b100, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1);
    alu_vec("pass_b",    3'b101, 8'h11, 8'h2A, 1'b1, 8'h2A, 1'b0, 1'b0);
    alu_vec("pass_a",    3'b110, 8'h5C, 8'h2A, 1'b0, 8'h5C, 1'b0, 1'b0);
    alu_vec("not_a",     3'b111, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);

    // Shifter: dir 0=left 1=right; sh_robar 1=logical 0=rotate
    sh_vec("shl1",  8'h81, 3'd1, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
    sh_vec("shr1",  8'h81, 3'd1, 1'b1, 1'b1, 8'h40, 1'b1, 1'b0);
    sh_vec("rol1",  8'h81, 3'd1, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0);
    sh_vec("ror3",  8'h81, 3'd3, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0);
    sh_vec("shr_z", 8'h01, 3'd1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1);
    sh_vec("shl7",  8'h03, 3'd7, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0);
    sh_vec("shr7",  8'hC0, 3'd7, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
    sh_vec("rol4",  8'h1E, 3'd4, 1'b0, 1'b0, 8'hE1, 1'b1, 1'b0);
    sh_vec("ror7",  8'h81, 3'd7, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0);
    sh_vec("n0_shl",8'h81, 3'd0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0);
    sh_vec("n0_shr",8'h81, 3'd0, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0);
    sh_vec("n0_rol",8'h81, 3'd0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0);
    sh_vec("n0_ror",8'h00, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

    // Memory: reset, writes, hold, boundaries
    @(posedge clk); #1;
    mem_rd("rst_rd10", 8'h10, 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;
    mem_rd("post_rst10", 8'h10, 8'h00);
    mem_wr(8'h10, 8'hA5);
    mem_rd("wr10", 8'h10, 8'hA5);
    mem_wr(8'hFF, 8'h3C);
    mem_rd("wrFF", 8'hFF, 8'h3C);
    mem_rd("10_kept", 8'h10, 8'hA5);

    mem_addr = 8'h10; mem_write_data = 8'h77; mem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold10", {1'b0, mem_out_data}, {1'b0, 8'hA5});

    mem_write = 1'bx; mem_write_data = 8'h99;
    @(posedge clk); #1;
    mem_write = 1'b0;
    chk("x_we10", {1'b0, mem_out_data}, {1'b0, 8'hA5});

    mem_wr(8'h00, 8'h5A);
    mem_rd("wr00", 8'h00, 8'h5A);
    mem_rd("FF_kept", 8'hFF, 8'h3C);
    mem_rd("01_zero", 8'h01, 8'h00);
    mem_rd("FE_zero", 8'hFE, 8'h00);

    // Read-during-write: old value before the edge, new after
    mem_addr = 8'h20; mem_write_data = 8'hC3; mem_write = 1'b1;
    #1;
    chk("rdw_old", {1'b0, mem_out_data}, {1'b0, 8'h00});
    @(posedge clk); #1;
    mem_write = 1'b0;
    chk("rdw_new", {1'b0, mem_out_data}, {1'b0, 8'hC3});

    // Combinational read follows address with no clock edge
    mem_addr = 8'h10; #1;
    chk("comb_rd", {1'b0, mem_out_data}, {1'b0, 8'hA5});

    // Asynchronous reset between edges
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async_rst", {1'b0, mem_out_data}, {1'b0, 8'h00});
    mem_addr = 8'hFF; mem_write_data = 8'hEE; mem_write = 1'b1;
    @(posedge clk); #1;
    chk("we_in_rst", {1'b0, mem_out_data}, {1'b0, 8'h00});
    mem_write = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    mem_rd("rst_00", 8'h00, 8'h00);
    mem_rd("rst_10", 8'h10, 8'h00);
    mem_rd("rst_20", 8'h20, 8'h00);
    mem_rd("rst_FF", 8'hFF, 8'h00);

    // Memory works again after reset
    mem_wr(8'h42, 8'h24);
    mem_rd("post_wr42", 8'h42, 8'h24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
